q3_sweep_ctrl: RTL and testbench
================================

# q3_sweep_ctrl

Sequential exhaustive-stimulus controller for the 3-input combinational `q3` block (inputs A, B, C; outputs F1, F2). On a start pulse it walks A,B,C through all 8 combinations in binary order, holding each vector for a programmable number of cycles. At the end of each hold it samples F1/F2 into two 8-bit captured truth tables. The block sits directly upstream of `q3` (drives its inputs) and closes the loop on its outputs, replacing hand-written `#5` stimulus with a clocked, self-timed sweep.

## Interface
- DWELL, default 5: cycles each vector is held before sampling; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; one clock; acts on rising edge of clk.
- start  input  1  request a sweep; sampled only in IDLE.
- A  output  1  stimulus MSB to q3.
- B  output  1  stimulus middle bit to q3.
- C  output  1  stimulus LSB to q3.
- F1  input  1  q3 response 1.
- F2  input  1  q3 response 2.
- busy  output  1  high while vectors are being swept.
- done  output  1  one-cycle pulse when the sweep completes.
- vec_idx  output  3  current vector index, equal to {A,B,C}.
- tt_f1  output  8  captured F1; bit i = F1 when {A,B,C}=i.
- tt_f2  output  8  captured F2; bit i = F2 when {A,B,C}=i.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE:
  - {A,B,C}=000, busy=0, done=0.
  - start=1 at an edge -> DRIVE. The same edge sets idx=0 and dwell counter cnt=0, and clears tt_f1/tt_f2 to 0.
- DRIVE:
  - busy=1; {A,B,C}=vec_idx=idx.
  - Each edge with cnt<DWELL-1: cnt+1.
  - Edge with cnt==DWELL-1: tt_f1[idx]<=F1, tt_f2[idx]<=F2, cnt<=0.
    - If idx<7: idx+1.
    - If idx==7: idx<=0 and next state DONE.
- DONE: busy=0, done=1 for exactly one cycle, {A,B,C}=000; next edge -> IDLE.
- start is ignored in DRIVE and DONE; there is no queuing.
- tt_f1/tt_f2 hold their values after DONE until the next accepted start.
- cnt is 8 bits wide; idx is 3 bits wide and wraps only via the explicit reset to 0.
- F1/F2 are sampled with no internal synchronizer, because q3 is same-clock combinational logic.
- Reset values: A=B=C=0, vec_idx=0, busy=0, done=0, tt_f1=tt_f2=8'h00, state IDLE.
- rst mid-sweep: the next edge forces full reset values; the partial truth tables are discarded.
- rst and start high on the same edge: rst wins and the sweep does not start.

## Timing
- Let E0 be the edge at which start is accepted.
- Vector k (0..7) is driven from after edge E0+k·DWELL to after edge E0+(k+1)·DWELL.
- Vector k is sampled on edge E0+(k+1)·DWELL.
- done is high in the cycle after edge E0+8·DWELL. The block is back in IDLE after E0+8·DWELL+1, and a new start is accepted at that edge or later.
- Total sweep: 8·DWELL+1 cycles from acceptance to IDLE.
- DWELL=1: a new vector every cycle; the sample is taken on the edge that advances idx.
- busy rises after E0 and falls on the same edge done rises.

## Test plan
- Reset: assert rst for 2 cycles with start=1 -> all outputs 0, busy stays 0, state IDLE.
- Full sweep, DWELL=5, bench model F1=A&B, F2=A^B^C:
  - {A,B,C} steps 000..111, changing every 5 cycles.
  - done pulses once, exactly 41 cycles after acceptance.
  - Result: tt_f1=8'hC0, tt_f2=8'h96.
- DWELL=1, model F1=~C, F2=A:
  - Vectors change every cycle; done 9 cycles after acceptance.
  - Result: tt_f1=8'h55, tt_f2=8'hF0.
- start pulsed repeatedly during DRIVE and in the DONE cycle -> no restart, no extra done; sweep length unchanged; a start one cycle after done begins a fresh sweep with the tables cleared.
- rst asserted while vec_idx=3 -> next cycle A=B=C=0, busy=0, tt_f1=tt_f2=0; no done pulse.
- Back-to-back sweeps with different models (F1=1, then F1=0) -> tt_f1=8'hFF, then 8'h00; the first result is held stable between the sweeps.

Source files
------------

// File: rtl/q3_sweep_ctrl.sv
// rtl/q3_sweep_ctrl.sv - exhaustive 3-input stimulus sweep with truth-table capture
//
// Purpose: on an accepted start, walks {A,B,C} through 000..111, holds each
// vector for DWELL cycles and samples the downstream F1/F2 responses into two
// 8-bit truth tables at the end of each hold.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   sweep request, honoured only in IDLE
//   A,B,C    out  stimulus vector (A = MSB)
//   F1,F2    in   responses from the same-clock combinational block
//   busy     out  high while vectors are being swept
//   done     out  one-cycle pulse after the last sample
//   vec_idx  out  current vector index, equal to {A,B,C}
//   tt_f1    out  captured F1, bit i = F1 for vector i
//   tt_f2    out  captured F2, bit i = F2 for vector i

module q3_sweep_ctrl #(
  parameter int unsigned DWELL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F1,
  input  logic       F2,
  output logic       busy,
  output logic       done,
  output logic [2:0] vec_idx,
  output logic [7:0] tt_f1,
  output logic [7:0] tt_f2
);

  localparam logic [7:0] LP_CNT_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_tt_f1;
  logic [7:0] r_tt_f2;
  logic       w_hold_end;
  logic       w_busy;
  logic       w_done;
  logic [2:0] w_vec;

  assign w_hold_end = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_vec        = 3'd0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_busy = 1'b1;
        w_vec  = r_idx;
        if (w_hold_end && (r_idx == 3'd7)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Dwell counter, vector index and truth-table capture. F1/F2 are taken
  // directly: they are combinational functions of this block's own outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
      r_tt_f1 <= 8'h00;
      r_tt_f2 <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= 3'd0;
            r_cnt   <= 8'd0;
            r_tt_f1 <= 8'h00;
            r_tt_f2 <= 8'h00;
          end
        end
        ST_DRIVE: begin
          if (w_hold_end) begin
            r_tt_f1[r_idx] <= F1;
            r_tt_f2[r_idx] <= F2;
            r_cnt          <= 8'd0;
            r_idx          <= (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign A       = w_vec[2];
  assign B       = w_vec[1];
  assign C       = w_vec[0];
  assign vec_idx = w_vec;
  assign busy    = w_busy;
  assign done    = w_done;
  assign tt_f1   = r_tt_f1;
  assign tt_f2   = r_tt_f2;

endmodule

// File: tb/tb_q3_sweep_ctrl.sv
// tb/tb_q3_sweep_ctrl.sv - self-checking bench for q3_sweep_ctrl (DWELL=5 and DWELL=1)

module tb_q3_sweep_ctrl;

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [7:0] tbl1 [2];
  logic [7:0] tbl2 [2];
  logic       a [2];
  logic       b [2];
  logic       c [2];
  logic       f1 [2];
  logic       f2 [2];
  logic       busy [2];
  logic       done [2];
  logic [2:0] vec [2];
  logic [7:0] tt1 [2];
  logic [7:0] tt2 [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for q3: outputs looked up from a truth table.
  assign f1[0] = tbl1[0][{a[0], b[0], c[0]}];
  assign f2[0] = tbl2[0][{a[0], b[0], c[0]}];
  assign f1[1] = tbl1[1][{a[1], b[1], c[1]}];
  assign f2[1] = tbl2[1][{a[1], b[1], c[1]}];

  q3_sweep_ctrl #(.DWELL(5)) u_d5 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .A(a[0]), .B(b[0]), .C(c[0]), .F1(f1[0]), .F2(f2[0]),
    .busy(busy[0]), .done(done[0]), .vec_idx(vec[0]),
    .tt_f1(tt1[0]), .tt_f2(tt2[0])
  );

  q3_sweep_ctrl #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .A(a[1]), .B(b[1]), .C(c[1]), .F1(f1[1]), .F2(f2[1]),
    .busy(busy[1]), .done(done[1]), .vec_idx(vec[1]),
    .tt_f1(tt1[1]), .tt_f2(tt2[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Truth tables of simple boolean models of {A,B,C}.
  function automatic logic [7:0] tab(input int model);
    logic [7:0] t;
    logic va, vb, vc;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      va = 1'((i >> 2) & 1);
      vb = 1'((i >> 1) & 1);
      vc = 1'(i & 1);
      case (model)
        0: t[i] = va & vb;
        1: t[i] = va ^ vb ^ vc;
        2: t[i] = ~vc;
        3: t[i] = va;
        4: t[i] = 1'b1;
        default: t[i] = 1'b0;
      endcase
    end
    return t;
  endfunction

  task automatic chk_idle(input int w, input logic [7:0] e1, input logic [7:0] e2);
    chk("idle_busy", 32'(busy[w]), 32'd0);
    chk("idle_done", 32'(done[w]), 32'd0);
    chk("idle_vec",  32'(vec[w]), 32'd0);
    chk("idle_abc",  32'({a[w], b[w], c[w]}), 32'd0);
    chk("idle_tt_f1", 32'(tt1[w]), 32'(e1));
    chk("idle_tt_f2", 32'(tt2[w]), 32'(e2));
  endtask

  // One sweep, checked cycle by cycle from the timing rules: after edge E0+n,
  // vector n/DWELL is driven and n/DWELL vectors have been sampled.
  task automatic sweep(input int w, input logic [7:0] t1, input logic [7:0] t2,
                       input logic [7:0] e1, input logic [7:0] e2, input bit noisy);
    int d;
    int k;
    logic [7:0] m;
    d = (w == 0) ? 5 : 1;
    tbl1[w] = t1;
    tbl2[w] = t2;
    start_v[w] = 1'b1;
    step();
    start_v[w] = 1'b0;
    for (int n = 0; n <= 8 * d; n++) begin
      k = n / d;
      m = (k >= 8) ? 8'hFF : 8'((1 << k) - 1);
      if (n < 8 * d) begin
        chk("sweep_busy", 32'(busy[w]), 32'd1);
        chk("sweep_done", 32'(done[w]), 32'd0);
        chk("sweep_vec",  32'(vec[w]), 32'(k));
        chk("sweep_abc",  32'({a[w], b[w], c[w]}), 32'(k));
      end else begin
        chk("done_busy", 32'(busy[w]), 32'd0);
        chk("done_pulse", 32'(done[w]), 32'd1);
        chk("done_abc",  32'({a[w], b[w], c[w]}), 32'd0);
      end
      chk("sweep_tt_f1", 32'(tt1[w]), 32'(e1 & m));
      chk("sweep_tt_f2", 32'(tt2[w]), 32'(e2 & m));
      if (noisy) start_v[w] = 1'($urandom_range(0, 1));
      step();
      start_v[w] = 1'b0;
    end
    chk_idle(w, e1, e2);
  endtask

  initial begin
    logic [7:0] r1;
    logic [7:0] r2;
    bit         hit;

    rst_v   = 2'b11;
    start_v = 2'b11;
    tbl1[0] = 8'h00; tbl1[1] = 8'h00;
    tbl2[0] = 8'h00; tbl2[1] = 8'h00;

    // Reset held two cycles with start high: must not start.
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle(0, 8'h00, 8'h00);
      chk_idle(1, 8'h00, 8'h00);
    end
    rst_v   = 2'b00;
    start_v = 2'b00;
    step();
    chk_idle(0, 8'h00, 8'h00);
    chk_idle(1, 8'h00, 8'h00);

    // Directed model sweeps.
    sweep(0, tab(0), tab(1), 8'hC0, 8'h96, 1'b0);
    sweep(1, tab(2), tab(3), 8'h55, 8'hF0, 1'b0);

    // Start chatter during DRIVE/DONE, then a fresh sweep right after.
    r1 = 8'($urandom); r2 = 8'($urandom);
    sweep(0, r1, r2, r1, r2, 1'b1);
    r1 = 8'($urandom); r2 = 8'($urandom);
    sweep(0, r1, r2, r1, r2, 1'b0);

    // Randomized tables on both dwell settings.
    for (int it = 0; it < 4; it++) begin
      r1 = 8'($urandom); r2 = 8'($urandom);
      sweep(1, r1, r2, r1, r2, 1'b1);
      r1 = 8'($urandom); r2 = 8'($urandom);
      sweep(0, r1, r2, r1, r2, 1'b1);
    end

    // Reset in the middle of a sweep at vector 3.
    tbl1[0] = 8'hFF; tbl2[0] = 8'hFF;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (vec[0] == 3'd3) hit = 1'b1;
      else step();
    end
    chk("midrst_reach_vec3", 32'(hit), 32'd1);
    chk("midrst_partial_tt", 32'(tt1[0]), 32'h07);
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    chk_idle(0, 8'h00, 8'h00);
    for (int i = 0; i < 45; i++) begin
      step();
      chk("midrst_no_done", 32'(done[0]), 32'd0);
      chk("midrst_no_busy", 32'(busy[0]), 32'd0);
    end

    // Back-to-back sweeps; first result must hold while idle.
    sweep(0, tab(4), 8'h00, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_idle(0, 8'hFF, 8'h00);
    end
    sweep(0, tab(5), 8'h00, 8'h00, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
